// File: rtl/seg_disp_pkg.sv
// Shared types, segment lookup table and width helpers for the 7-segment scan driver
// and its reusable nibble decoder.
package seg_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high {dp,g,f,e,d,c,b,a}; bit 7 is always clear here, dp is merged in hex_to_seg.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_e;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
    return {dp, SEG_LUT[nibble][6:0]};
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Host-side bus of the scan driver: run control, load strobe with digit data, frame pulse.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    frame_done;

  modport master (
    output enable, load, data_in, dp_in, blank_in,
    input  frame_done
  );

  modport slave (
    input  enable, load, data_in, dp_in, blank_in,
    output frame_done
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal point + blank to active-high 7-segment pattern.
module seg_hex_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : hex_to_seg(nibble_i, dp_i);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scan driver with guard cycles and frame-aligned double buffer.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits of the active value.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int GUARD_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_display_if.slave     bus,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int IDX_W   = cnt_w(NUM_DIGITS);
  localparam int PRESC_W = cnt_w(DIV);
  localparam int GRD_W   = cnt_w(GUARD_CYCLES + 1);

  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESC_W-1:0]    PRESC_MAX = PRESC_W'(DIV - 1);
  localparam logic [GRD_W-1:0]      GRD_INIT  = GRD_W'(GUARD_CYCLES);
  localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? '1 : '0;

  scan_state_e             state_q;
  logic [PRESC_W-1:0]      presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [GRD_W-1:0]        guard_q;
  logic [4*NUM_DIGITS-1:0] act_data_q, pend_data_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_blank_q, pend_dp_q, pend_blank_q;
  logic                    pend_vld_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic                    scan_c, tick_c, wrap_c;
  logic [NUM_DIGITS-1:0]   lz_blank_c;
  logic [7:0]              dec_seg_c;

  assign scan_c = (state_q == ST_SCAN) && bus.enable;
  assign tick_c = scan_c && (presc_q == PRESC_MAX);
  assign wrap_c = tick_c && (idx_q == IDX_MAX);

  assign bus.frame_done = wrap_c;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; digit 0 always stays visible.
  always_comb begin
    logic lead;
    lead       = 1'b1;
    lz_blank_c = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead          = lead && (act_data_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
      lz_blank_c[k] = lead;
    end
  end
`else
  assign lz_blank_c = '0;
`endif

  seg_hex_decode u_dec (
    .nibble_i (act_data_q[4*idx_q +: 4]),
    .dp_i     (act_dp_q[idx_q]),
    .blank_i  (act_blank_q[idx_q] | lz_blank_c[idx_q]),
    .seg_o    (dec_seg_c)
  );

  // Pin polarity is folded in here so the decoder stays active-high.
  always_comb begin
    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    if (scan_c && (guard_q == '0)) begin
      seg_d = dec_seg_c ^ SEG_OFF;
      dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      idx_q        <= '0;
      guard_q      <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;

      case (state_q)
        ST_IDLE: begin
          presc_q <= '0;
          idx_q   <= '0;
          guard_q <= '0;
          if (bus.enable) begin
            state_q <= ST_SCAN;
            guard_q <= GRD_INIT;
          end
        end
        ST_SCAN: begin
          if (!bus.enable) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            idx_q   <= '0;
            guard_q <= '0;
          end else if (tick_c) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            guard_q <= GRD_INIT;
          end else begin
            presc_q <= presc_q + 1'b1;
            if (guard_q != '0) guard_q <= guard_q - 1'b1;
          end
        end
      endcase

      // While dark, loads go straight to the active buffer; while scanning they wait for a wrap.
      if (!bus.enable) begin
        if (bus.load) begin
          act_data_q  <= bus.data_in;
          act_dp_q    <= bus.dp_in;
          act_blank_q <= bus.blank_in;
          pend_vld_q  <= 1'b0;
        end
      end else begin
        if (wrap_c && pend_vld_q) begin
          act_data_q  <= pend_data_q;
          act_dp_q    <= pend_dp_q;
          act_blank_q <= pend_blank_q;
          pend_vld_q  <= 1'b0;
        end
        if (bus.load) begin
          pend_data_q  <= bus.data_in;
          pend_dp_q    <= bus.dp_in;
          pend_blank_q <= bus.blank_in;
          pend_vld_q   <= 1'b1;
        end
      end
    end
  end

  assign seg_out = seg_q;
  assign dig_sel = dig_q;

endmodule
